lsu_data_mem: RTL and testbench
===============================

LSU_DATA_MEM -- requirements
Module: lsu_data_mem

Interface
REQ-001 The module SHALL take parameter ADDR_W, default 7, giving the byte-address width; DEPTH = 2^(ADDR_W-2) words of 32 bits (default 32 words).
REQ-002 The module SHALL take parameter CLEAR_ON_RST, default 1: 1 = walk-clear the whole array after reset; 0 = skip clear and go straight to IDLE.
REQ-003 clk  input  1  single clock, all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 rsp_valid  output  1  one-cycle response pulse.
REQ-012 rsp_rdata  output  32  load result, already extended; 0 for stores and errors.
REQ-013 rsp_err  output  1  qualified by rsp_valid: misaligned or illegal funct3.
REQ-014 busy  output  1  high while in CLEAR.

Function
REQ-015 The FSM SHALL have two states: CLEAR and IDLE.
- CLEAR -> IDLE when clear_cnt == DEPTH-1 is written.
- IDLE stays in IDLE; only rst leaves it.
REQ-016 In CLEAR the block SHALL write 0 to mem[clear_cnt] each cycle, increment clear_cnt, and hold req_ready=0 and busy=1; full clear takes exactly DEPTH cycles.
REQ-017 In IDLE req_ready SHALL be 1 and busy SHALL be 0; a request is accepted on a cycle with req_valid && req_ready.
REQ-018 Responses SHALL have no backpressure: rsp_valid is asserted exactly one cycle after every accepted request and is 0 otherwise.
REQ-019 The word index SHALL be req_addr[ADDR_W-1:2] and the byte offset req_addr[1:0].
REQ-020 Legal loads SHALL be: LB=000, LH=001, LW=010, LBU=100, LHU=101.
REQ-021 Legal stores SHALL be: SB=000, SH=001, SW=010.
REQ-022 Any other funct3 SHALL produce rsp_err=1, rsp_rdata=0, and no memory write.
REQ-023 Misalignment SHALL be defined as: a half access with addr[0]=1, or a word access with addr[1:0]!=0.
REQ-024 A misaligned access SHALL produce rsp_err=1, rsp_rdata=0, and no memory write.
REQ-025 Stores SHALL write on the acceptance edge, using byte lanes only.
- SB writes byte lane addr[1:0] with wdata[7:0].
- SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
- SW writes all four lanes.
- Unselected lanes are unchanged.
REQ-026 Loads SHALL capture the selected lane(s) on the acceptance edge and present them the next cycle.
- LB/LH: sign-extended to 32 bits.
- LBU/LHU: zero-extended to 32 bits.
- LW: the full word.
REQ-027 A store response SHALL be rsp_valid=1, rsp_err=0, rsp_rdata=0.
REQ-028 Back-to-back requests SHALL be accepted every cycle. A load accepted the cycle after a store to the same word SHALL return the post-store data, since the write commits on the earlier edge.
REQ-029 The block SHALL support one request per cycle, with no internal queueing and no simultaneous read/write port conflict.
REQ-030 Accesses SHALL wrap: the address width bounds the array, so no out-of-range condition exists.

Reset
REQ-031 While rst=1 the block SHALL hold:
- rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0;
- clear_cnt=0;
- state=CLEAR if CLEAR_ON_RST=1, otherwise IDLE.
REQ-032 A request pending in the cycle rst rises SHALL be discarded: no response pulse is produced and no write occurs.
REQ-033 rst asserted mid-CLEAR SHALL restart the clear from word 0.
REQ-034 With CLEAR_ON_RST=0, array contents SHALL be left unchanged by reset.

Verification
REQ-035 Reset clear: rst 1 cycle, then idle -> busy=1 and req_ready=0 for exactly DEPTH (32) cycles; afterwards LW at 0x00..0x7C returns 0x00000000.
REQ-036 Sub-word store/load: SW 0x11223344 @0x08, SB 0xAB @0x09, SH 0x8001 @0x0A.
- LW @0x08 -> 0x8001AB44.
- LB @0x09 -> 0xFFFFFFAB.
- LBU @0x09 -> 0x000000AB.
- LH @0x0A -> 0xFFFF8001.
- LHU @0x0A -> 0x00008001.
REQ-037 Misaligned and illegal accesses:
- SW 0xDEADBEEF @0x11 -> rsp_err=1, and a later LW @0x10 is unchanged.
- LH @0x03 -> rsp_err=1, rdata=0.
- funct3=011 -> rsp_err=1.
REQ-038 Back-to-back forwarding: SW 0xCAFEF00D @0x20 in cycle N, LW @0x20 in cycle N+1 -> rsp at N+2 = 0xCAFEF00D; rsp_valid high in both N+1 and N+2.
REQ-039 Reset mid-clear: assert rst at clear_cnt=10 -> clear restarts, busy lasts a further 32 cycles, and a request during busy is not accepted (no rsp_valid).
REQ-040 Address wrap: SW 0x5A5A5A5A @0x80 with ADDR_W=7 lands at word 0 -> LW @0x00 = 0x5A5A5A5A.

Source files
------------

// File: rtl/lsu_data_mem.sv
// Word-organised data memory behind a load/store unit request port.
// Walk-clears after reset, then serves one RV32I load/store per cycle.
module lsu_data_mem #(
  parameter int ADDR_W       = 7,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_clear_cnt;
  logic [31:0]      r_mem [DEPTH];

  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_off;
  logic [1:0]       w_size;
  logic             w_legal;
  logic             w_misal;
  logic             w_err;
  logic             w_accept;
  logic [31:0]      w_word;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ld;
  logic             w_we;
  logic [IDX_W-1:0] w_widx;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;

  assign req_ready = (r_state == S_IDLE) && !rst;
  assign busy      = (r_state == S_CLEAR);
  assign w_accept  = req_valid && req_ready;

  assign w_idx  = req_addr[ADDR_W-1:2];
  assign w_off  = req_addr[1:0];
  assign w_size = req_funct3[1:0];

  always_comb begin
    w_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !req_we;
      default:                w_legal = 1'b0;
    endcase
  end

  assign w_misal = (w_size == 2'b01 && w_off[0])
                || (w_size == 2'b10 && w_off != 2'b00);
  assign w_err   = !w_legal || w_misal;

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_off, 3'b000} +: 8];
  assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_ld = w_word;
    case (req_funct3)
      3'b000:  w_ld = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld = {24'd0, w_byte};
      3'b101:  w_ld = {16'd0, w_half};
      default: w_ld = w_word;
    endcase
  end

  // Clear and store share the single write port; they never coincide.
  always_comb begin
    w_we    = 1'b0;
    w_widx  = w_idx;
    w_be    = 4'h0;
    w_wdata = 32'd0;
    if (r_state == S_CLEAR && !rst) begin
      w_we    = 1'b1;
      w_widx  = r_clear_cnt;
      w_be    = 4'hF;
    end else if (w_accept && req_we && !w_err) begin
      w_we = 1'b1;
      case (w_size)
        2'b00: begin
          w_be    = 4'b0001 << w_off;
          w_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = w_off[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'hF;
          w_wdata = req_wdata;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_widx][i*8 +: 8] <= w_wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CLEAR_ON_RST ? S_CLEAR : S_IDLE;
      r_clear_cnt <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= 32'd0;
    end else begin
      rsp_valid <= w_accept;
      rsp_err   <= w_accept && w_err;
      rsp_rdata <= (w_accept && !req_we && !w_err) ? w_ld : 32'd0;
      if (r_state == S_CLEAR) begin
        r_clear_cnt <= r_clear_cnt + 1'b1;
        if (r_clear_cnt == {IDX_W{1'b1}}) r_state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_lsu_data_mem.sv
// Directed plus random checks of lsu_data_mem against a byte-array model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lsu_data_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mb [128];
  logic        e_err;
  logic [31:0] e_data;
  logic [31:0] o_data;
  logic        o_err;

  always #5 clk = ~clk;

  lsu_data_mem #(.ADDR_W(7), .CLEAR_ON_RST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic we, input logic [2:0] f3,
                       input logic [6:0] a, input logic [31:0] wd,
                       output logic err, output logic [31:0] d);
    int n;
    bit legal;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2})
               : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err = !legal || ((int'(a) % n) != 0);
    d = 32'd0;
    if (err) return;
    if (we) begin
      for (int k = 0; k < n; k++) mb[int'(a) + k] = wd[8*k +: 8];
    end else begin
      for (int k = 0; k < n; k++) d = d | (32'(mb[int'(a) + k]) << (8*k));
      if (!f3[2] && n < 4 && d[8*n-1])
        d = d | ~((32'd1 << (8*n)) - 32'd1);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [6:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    model(we, f3, a, wd, e_err, e_data);
    @(negedge clk);
    req_valid = 1'b0;
    o_data = rsp_rdata;
    o_err  = rsp_err;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_err", 32'(rsp_err), 32'(e_err));
    check("rsp_rdata", rsp_rdata, e_data);
    @(negedge clk);
    check("rsp_idle", 32'(rsp_valid), 32'd0);
  endtask

  task automatic count_busy(input string tag);
    int n;
    int seen;
    n = 0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      if (req_ready) seen++;
      if (rsp_valid) seen++;
      n++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check({tag, "_len"}, n, 32);
    check({tag, "_noaccept"}, seen, 0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    for (int j = 0; j < 128; j++) mb[j] = 8'h00;
  endtask

  initial begin
    logic [7:0] a8;
    rst = 1'b1;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 7'h04;
    req_wdata = 32'h12345678;
    @(negedge clk);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    req_valid = 1'b0;
    count_busy("clear");

    for (int i = 0; i < 32; i++) do_req(1'b0, 3'b010, 7'(i*4), 32'd0);

    do_req(1'b1, 3'b010, 7'h08, 32'h11223344);
    do_req(1'b1, 3'b000, 7'h09, 32'hFFFFFFAB);
    do_req(1'b1, 3'b001, 7'h0A, 32'h00008001);
    do_req(1'b0, 3'b010, 7'h08, 32'd0);
    check("lw08", o_data, 32'h8001AB44);
    do_req(1'b0, 3'b000, 7'h09, 32'd0);
    check("lb09", o_data, 32'hFFFFFFAB);
    do_req(1'b0, 3'b100, 7'h09, 32'd0);
    check("lbu09", o_data, 32'h000000AB);
    do_req(1'b0, 3'b001, 7'h0A, 32'd0);
    check("lh0a", o_data, 32'hFFFF8001);
    do_req(1'b0, 3'b101, 7'h0A, 32'd0);
    check("lhu0a", o_data, 32'h00008001);

    do_req(1'b1, 3'b010, 7'h11, 32'hDEADBEEF);
    check("sw_mis_err", 32'(o_err), 32'd1);
    do_req(1'b0, 3'b010, 7'h10, 32'd0);
    check("lw10", o_data, 32'h00000000);
    do_req(1'b0, 3'b001, 7'h03, 32'd0);
    check("lh_mis_err", 32'(o_err), 32'd1);
    do_req(1'b0, 3'b011, 7'h00, 32'd0);
    check("f3_011_err", 32'(o_err), 32'd1);
    do_req(1'b1, 3'b100, 7'h0C, 32'hFFFFFFFF);
    check("st_100_err", 32'(o_err), 32'd1);

    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 7'h20;
    req_wdata = 32'hCAFEF00D;
    model(1'b1, 3'b010, 7'h20, 32'hCAFEF00D, e_err, e_data);
    @(negedge clk);
    check("b2b_sw_valid", 32'(rsp_valid), 32'd1);
    check("b2b_sw_rdata", rsp_rdata, 32'd0);
    req_we = 1'b0;
    req_wdata = 32'd0;
    model(1'b0, 3'b010, 7'h20, 32'd0, e_err, e_data);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_lw_valid", 32'(rsp_valid), 32'd1);
    check("b2b_lw_rdata", rsp_rdata, 32'hCAFEF00D);
    @(negedge clk);
    check("b2b_idle", 32'(rsp_valid), 32'd0);

    a8 = 8'h80;
    do_req(1'b1, 3'b010, a8[6:0], 32'h5A5A5A5A);
    do_req(1'b0, 3'b010, 7'h00, 32'd0);
    check("wrap_lw00", o_data, 32'h5A5A5A5A);

    for (int i = 0; i < 300; i++) begin
      logic [2:0] f3;
      logic [6:0] a;
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) :
           3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'b100 : 3'b000);
      a = 7'($urandom);
      if ($urandom_range(0, 3) != 0) a[1:0] = f3[1] ? 2'b00 : {a[1], 1'b0};
      do_req(1'($urandom), f3, a, $urandom);
    end

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_funct3 = 3'b010;
    req_addr = 7'h08;
    count_busy("reclear");
    for (int i = 0; i < 32; i += 3) do_req(1'b0, 3'b010, 7'(i*4), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
